// File: rtl/bus_responder_6502.sv
// bus_responder_6502: generates the 6502 phase clock and maps each bus cycle onto one
// req/ack transaction downstream, stretching phi2 while a read is still outstanding.
module bus_responder_6502 #(
  parameter int PHI_DIV = 4
) (
  input  logic        clk,
  input  logic        res,
  output logic        phi,
  input  logic [15:0] ab,
  input  logic        rw,
  input  logic        sync,
  input  logic [7:0]  dbo,
  output logic [7:0]  dbi,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_fetch,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);
  localparam int CW = $clog2(PHI_DIV);
  localparam logic [CW-1:0] CMAX = CW'(PHI_DIV - 1);
  typedef enum logic [1:0] {PHI1, PHI2, STRETCH} state_e;
  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, fetch_q, fetch_d, rw_q, rw_d, acked_q, acked_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d, dbi_q, dbi_d;
  logic        done, last;
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    fetch_d = fetch_q;
    rw_d    = rw_q;
    acked_d = acked_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dbi_d   = dbi_q;
    done    = req_q & mem_ack;
    last    = cnt_q == CMAX;
    cnt_d   = last ? cnt_q : cnt_q + 1'b1;
    if (done) begin
      req_d = 1'b0;
      if (!we_q) begin
        dbi_d   = mem_rdata;
        acked_d = 1'b1;
      end
    end
    // A posted write still pending keeps phi1 saturated until its ack retires it
    case (state_q)
      PHI1: if (last && !req_q) begin
        addr_d  = ab;
        rw_d    = rw;
        fetch_d = sync;
        we_d    = 1'b0;
        req_d   = rw;
        acked_d = 1'b0;
        cnt_d   = '0;
        state_d = PHI2;
      end
      PHI2: if (last) begin
        cnt_d = '0;
        if (!rw_q) begin
          wdata_d = dbo;
          req_d   = 1'b1;
          we_d    = 1'b1;
          state_d = PHI1;
        end else state_d = (acked_q || done) ? PHI1 : STRETCH;
      end
      STRETCH: if (done) begin
        cnt_d   = '0;
        state_d = PHI1;
      end
      default: state_d = PHI1;
    endcase
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= PHI1;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      fetch_q <= 1'b0;
      rw_q    <= 1'b1;
      acked_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dbi_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      fetch_q <= fetch_d;
      rw_q    <= rw_d;
      acked_q <= acked_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dbi_q   <= dbi_d;
    end
  end
  assign phi       = state_q != PHI1;
  assign dbi       = dbi_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_fetch = fetch_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_bus_responder_6502.sv
// tb_bus_responder_6502: directed bus cycles against a scoreboard of expected transactions,
// with phi timing measured in clk ticks.
module tb_bus_responder_6502;
  logic        clk = 1'b0, res = 1'b0, rw = 1'b1, sync = 1'b0, mem_ack = 1'b0;
  logic [15:0] ab = 16'h0;
  logic [7:0]  dbo = 8'h0, mem_rdata = 8'h0;
  logic        phi, mem_req, mem_we, mem_fetch;
  logic [7:0]  dbi, mem_wdata;
  logic [15:0] mem_addr;
  int checks = 0, failures = 0;
  typedef struct {logic [15:0] addr; logic we; logic fetch; logic [7:0] wdata;} txn_t;
  txn_t sb[$];

  bus_responder_6502 #(.PHI_DIV(4)) dut (
    .clk(clk), .res(res), .phi(phi), .ab(ab), .rw(rw), .sync(sync), .dbo(dbo),
    .dbi(dbi), .mem_req(mem_req), .mem_we(mem_we), .mem_fetch(mem_fetch),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, output int n);
    n = 0;
    while (!mem_req && n < 64) begin
      tick();
      n++;
    end
    if (!mem_req) chk({tag, "_req_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pop_cmp(input string tag, input logic wr);
    txn_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_addr"}, 32'(mem_addr), 32'(e.addr));
    chk({tag, "_we"}, 32'(mem_we), 32'(e.we));
    chk({tag, "_fetch"}, 32'(mem_fetch), 32'(e.fetch));
    if (wr) chk({tag, "_wdata"}, 32'(mem_wdata), 32'(e.wdata));
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic s, input int d,
                         input logic [7:0] rd, input int exp_n, input int exp_hi);
    int n, hi;
    ab = a; rw = 1'b1; sync = s;
    sb.push_back('{a, 1'b0, s, 8'h00});
    wait_req(tag, n);
    chk({tag, "_low_clks"}, 32'(n), 32'(exp_n));
    chk({tag, "_phi_at_req"}, 32'(phi), 32'd1);
    pop_cmp(tag, 1'b0);
    hi = 1;
    for (int i = 0; i < d; i++) begin
      tick();
      if (phi) hi++;
    end
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    if (phi) hi++;
    chk({tag, "_dbi"}, 32'(dbi), 32'(rd));
    chk({tag, "_req_drop"}, 32'(mem_req), 32'd0);
    for (int i = 0; i < 64 && phi; i++) begin
      tick();
      if (phi) hi++;
    end
    chk({tag, "_high_clks"}, 32'(hi), 32'(exp_hi));
  endtask

  task automatic do_write(input string tag, input logic [15:0] a, input logic [7:0] wd,
                          input int d, input int exp_n, input logic [7:0] exp_dbi);
    int n;
    ab = a; rw = 1'b0; sync = 1'b0; dbo = wd;
    sb.push_back('{a, 1'b1, 1'b0, wd});
    wait_req(tag, n);
    chk({tag, "_clks"}, 32'(n), 32'(exp_n));
    chk({tag, "_phi_at_req"}, 32'(phi), 32'd0);
    pop_cmp(tag, 1'b1);
    for (int i = 0; i < d; i++) tick();
    chk({tag, "_req_held"}, 32'(mem_req), 32'd1);
    chk({tag, "_phi1_hold"}, 32'(phi), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk({tag, "_req_drop"}, 32'(mem_req), 32'd0);
    chk({tag, "_dbi_kept"}, 32'(dbi), 32'(exp_dbi));
  endtask

  initial begin
    int n;
    ab = 16'hFFFC; rw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_phi", 32'(phi), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_dbi", 32'(dbi), 32'd0);
    end
    chk("rst_addr", 32'(mem_addr), 32'd0);
    res = 1'b1;
    do_read("rd_fast", 16'hFFFC, 1'b0, 1, 8'hA5, 4, 4);
    do_read("rd_slow", 16'h1234, 1'b0, 10, 8'hC3, 4, 11);
    do_write("wr_posted", 16'h0200, 8'h3C, 6, 8, 8'hC3);
    do_read("rd_after_wr", 16'h0201, 1'b0, 1, 8'h7E, 1, 4);
    do_read("rd_fetch", 16'hC000, 1'b1, 2, 8'hEA, 4, 4);
    do_read("rd_operand", 16'hC001, 1'b0, 1, 8'h4C, 4, 4);
    do_write("wr_zero_dly", 16'h0300, 8'hB1, 6, 8, 8'h4C);
    do_read("rd_dbi_zero", 16'h0000, 1'b0, 1, 8'h00, 1, 4);
    ab = 16'h8000; rw = 1'b1; sync = 1'b0;
    sb.push_back('{16'h8000, 1'b0, 1'b0, 8'h00});
    wait_req("rst_mid", n);
    pop_cmp("rst_mid", 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk("stretch_phi", 32'(phi), 32'd1);
    chk("stretch_req", 32'(mem_req), 32'd1);
    res = 1'b0;
    #1;
    chk("rst_async_req", 32'(mem_req), 32'd0);
    chk("rst_async_phi", 32'(phi), 32'd0);
    tick();
    tick();
    res = 1'b1;
    mem_ack = 1'b1; mem_rdata = 8'h99;
    tick();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    chk("late_ack_dbi", 32'(dbi), 32'd0);
    chk("late_ack_req", 32'(mem_req), 32'd0);
    do_read("rd_post_rst", 16'h9000, 1'b0, 1, 8'h12, 3, 4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
